synth_drum_voice: RTL and testbench

//  Parametrised percussion voice: NUM_OSC phase-accumulator oscillators (per-channel shape),
//  one shared attack/decay envelope FSM, optional LFSR noise channel, scaled mixer.

---
 rtl/synth_drum_voice_if.sv | 29 ++
 rtl/synth_drum_voice.sv | 203 ++++++++++++++++++++
 tb/tb_synth_drum_voice.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_drum_voice_if.sv
// Control and sample-output bundle for synth_drum_voice.
// master drives controls and consumes samples; slave is the voice itself.
interface synth_drum_voice_if #(
  parameter int unsigned NUM_OSC = 2,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned ENV_W   = 8
);
  logic                       sample_en;
  logic                       trigger;
  logic [NUM_OSC*ACC_W-1:0]   tone_freq;
  logic [NUM_OSC*2-1:0]       osc_shape;
  logic [ENV_W-1:0]           attack_rate;
  logic [ENV_W-1:0]           decay_rate;
  logic [ENV_W-1:0]           noise_gain;
  logic [WIDTH-1:0]           out;
  logic                       out_valid;
  logic                       busy;

  modport master (
    output sample_en, trigger, tone_freq, osc_shape, attack_rate, decay_rate, noise_gain,
    input  out, out_valid, busy
  );

  modport slave (
    input  sample_en, trigger, tone_freq, osc_shape, attack_rate, decay_rate, noise_gain,
    output out, out_valid, busy
  );
endinterface

// File: rtl/synth_drum_voice.sv
// Percussion voice: NUM_OSC tone oscillators, shared attack/decay envelope, scaled mixer.
// Define SYNTH_DRUM_NOISE_EN to add a 16-bit Galois LFSR noise channel.
module synth_drum_voice #(
  parameter int unsigned NUM_OSC = 2,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned ENV_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  synth_drum_voice_if.slave bus
);

`ifdef SYNTH_DRUM_NOISE_EN
  localparam int unsigned NCH = NUM_OSC + 1;
`else
  localparam int unsigned NCH = NUM_OSC;
`endif
  localparam int unsigned GW  = $clog2(NCH);
  localparam int unsigned SW  = WIDTH + GW;
  localparam int unsigned PW  = SW + ENV_W + 1;
  localparam int unsigned NPW = WIDTH + ENV_W + 1;

  localparam logic [WIDTH-1:0]        MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ENV_W-1:0]        ENV_MAX = '1;
  localparam logic signed [PW-1:0]    SAT_HI  = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    SAT_LO  = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ATTACK, DECAY} env_state_e;

  env_state_e              state, state_next;
  logic [ENV_W-1:0]        env, env_next;
  logic [ENV_W:0]          env_up_wide;
  logic [ENV_W-1:0]        env_up, env_down;
  logic                    clear_phase;
  logic                    busy_reg;

  logic [ACC_W-1:0]        phase     [NUM_OSC];
  logic [ACC_W-1:0]        phase_upd [NUM_OSC];
  logic signed [SW-1:0]    chan_sum;

  logic signed [SW-1:0]    s1_sum;
  logic [ENV_W-1:0]        s1_env;
  logic                    s1_valid;

  logic signed [PW-1:0]    prod, scaled;
  logic [WIDTH-1:0]        mix;
  logic [WIDTH-1:0]        out_reg;
  logic                    valid_reg;

  // Offset-binary waveform for one oscillator, returned as two's complement.
  function automatic logic signed [WIDTH-1:0] shape_sample(input logic [WIDTH-1:0] p,
                                                          input logic [1:0]       shape);
    logic [WIDTH-1:0] ramp;
    logic [WIDTH-1:0] u;
    ramp = {p[WIDTH-2:0], 1'b0};
    unique case (shape)
      2'b00:   u = p[WIDTH-1] ? '1 : '0;
      2'b01:   u = p[WIDTH-1] ? ~ramp : ramp;
      2'b10:   u = p;
      default: u = MID;
    endcase
    // Subtracting midscale from offset binary is a flip of the MSB.
    return $signed(u ^ MID);
  endfunction

  // Envelope step candidates, saturating at both ends.
  assign env_up_wide = {1'b0, env} + {1'b0, bus.attack_rate};
  assign env_up      = (bus.attack_rate == '0 || env_up_wide[ENV_W]) ? ENV_MAX
                                                                     : env_up_wide[ENV_W-1:0];
  assign env_down    = (bus.decay_rate >= env) ? '0 : env - bus.decay_rate;

  // Envelope FSM next state; a trigger overrides any coincident sample step.
  always_comb begin
    state_next  = state;
    env_next    = env;
    clear_phase = 1'b0;
    if (bus.trigger) begin
      state_next  = ATTACK;
      clear_phase = (state == IDLE);
    end else if (bus.sample_en) begin
      case (state)
        ATTACK: begin
          env_next = env_up;
          if (env_up == ENV_MAX) state_next = DECAY;
        end
        DECAY: begin
          env_next = env_down;
          if (env_down == '0) state_next = IDLE;
        end
        default: env_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      env      <= '0;
      busy_reg <= 1'b0;
    end else begin
      state    <= state_next;
      env      <= env_next;
      busy_reg <= (state_next != IDLE);
    end
  end

  // Phase accumulators; a fresh strike restarts every oscillator from zero.
  always_comb begin
    for (int i = 0; i < NUM_OSC; i++) begin
      if (clear_phase)        phase_upd[i] = '0;
      else if (bus.sample_en) phase_upd[i] = phase[i] + bus.tone_freq[i*ACC_W +: ACC_W];
      else                    phase_upd[i] = phase[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OSC; i++) phase[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OSC; i++) phase[i] <= phase_upd[i];
    end
  end

`ifdef SYNTH_DRUM_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]              lfsr, lfsr_upd;
  logic signed [WIDTH-1:0]  noise_s, noise_term;
  logic signed [NPW-1:0]    noise_prod;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_comb begin
    lfsr_upd = lfsr;
    if (bus.sample_en) lfsr_upd = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign noise_s    = $signed(lfsr_upd[15 -: WIDTH] ^ MID);
  assign noise_prod = NPW'(noise_s) * NPW'($signed({1'b0, bus.noise_gain}));
  assign noise_term = WIDTH'(noise_prod >>> ENV_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_upd;
  end
`else
  logic unused_noise_gain;
  assign unused_noise_gain = ^bus.noise_gain;
`endif

  // Channel sum in SW bits so NCH full-scale samples cannot overflow.
  always_comb begin
    chan_sum = '0;
    for (int i = 0; i < NUM_OSC; i++) begin
      chan_sum = chan_sum + SW'(shape_sample(phase_upd[i][ACC_W-1 -: WIDTH],
                                             bus.osc_shape[2*i +: 2]));
    end
`ifdef SYNTH_DRUM_NOISE_EN
    chan_sum = chan_sum + SW'(noise_term);
`endif
  end

  // Stage 1: capture channel sum and envelope for the advanced sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_sum   <= '0;
      s1_env   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.sample_en;
      if (bus.sample_en) begin
        s1_sum <= chan_sum;
        s1_env <= env_next;
      end
    end
  end

  // Stage 2: envelope multiply, scale by ENV_W plus channel guard bits, saturate.
  assign prod   = PW'(s1_sum) * PW'($signed({1'b0, s1_env}));
  assign scaled = prod >>> (ENV_W + GW);

  always_comb begin
    if (scaled > SAT_HI)      mix = SAT_HI[WIDTH-1:0];
    else if (scaled < SAT_LO) mix = SAT_LO[WIDTH-1:0];
    else                      mix = scaled[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg   <= MID;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= s1_valid;
      if (s1_valid) out_reg <= mix ^ MID;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_synth_drum_voice.sv
// Randomized bench for synth_drum_voice against a sample-level behavioural model.
// Noise-channel checks are compiled in when SYNTH_DRUM_NOISE_EN is defined.
module tb_synth_drum_voice;
  localparam int unsigned NUM_OSC = 2;
  localparam int unsigned WIDTH   = 12;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned ENV_W   = 8;
  localparam int MID     = 1 << (WIDTH - 1);
  localparam int FULL    = (1 << WIDTH) - 1;
  localparam int ENV_MAX = (1 << ENV_W) - 1;
`ifdef SYNTH_DRUM_NOISE_EN
  localparam int NCH = NUM_OSC + 1;
`else
  localparam int NCH = NUM_OSC;
`endif
  localparam int GUARD = $clog2(NCH);

  logic clk;
  logic reset;

  synth_drum_voice_if #(.NUM_OSC(NUM_OSC), .WIDTH(WIDTH), .ACC_W(ACC_W), .ENV_W(ENV_W)) bus ();

  synth_drum_voice #(.NUM_OSC(NUM_OSC), .WIDTH(WIDTH), .ACC_W(ACC_W), .ENV_W(ENV_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: per-oscillator phase, envelope level, "sounding" and "rising" flags.
  int m_phase [NUM_OSC];
  int m_env;
  bit m_busy;
  bit m_rising;
  int m_lfsr;
  bit pend_v;
  int pend_out;
  int last_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int osc_sample(input int phase, input int shape);
    int p, ramp, u;
    p    = phase >> (ACC_W - WIDTH);
    ramp = (2 * p) % (FULL + 1);
    case (shape)
      0:       u = (p >= MID) ? FULL : 0;
      1:       u = (p >= MID) ? FULL - ramp : ramp;
      2:       u = p;
      default: u = MID;
    endcase
    return u - MID;
  endfunction

  function automatic int expected_out();
    int sum, mix;
    sum = 0;
    for (int i = 0; i < NUM_OSC; i++)
      sum += osc_sample(m_phase[i], int'(bus.osc_shape[2*i +: 2]));
`ifdef SYNTH_DRUM_NOISE_EN
    sum += (((m_lfsr >> (16 - WIDTH)) - MID) * int'(bus.noise_gain)) >>> ENV_W;
`endif
    mix = ((sum * m_env) >>> ENV_W) >>> GUARD;
    if (mix > MID - 1) mix = MID - 1;
    if (mix < -MID)    mix = -MID;
    return mix + MID;
  endfunction

  task automatic model_init();
    for (int i = 0; i < NUM_OSC; i++) m_phase[i] = 0;
    m_env    = 0;
    m_busy   = 0;
    m_rising = 0;
    m_lfsr   = 'hACE1;
    pend_v   = 0;
    pend_out = MID;
    last_out = MID;
  endtask

  // One clock edge of the voice, expressed in sample-level terms.
  task automatic model_step(output bit v, output int o);
    bit se, tr;
    se = bus.sample_en;
    tr = bus.trigger;
    if (tr && !m_busy) begin
      for (int i = 0; i < NUM_OSC; i++) m_phase[i] = 0;
    end else if (se) begin
      for (int i = 0; i < NUM_OSC; i++)
        m_phase[i] = (m_phase[i] + int'(bus.tone_freq[i*ACC_W +: ACC_W])) % (1 << ACC_W);
    end
    if (tr) begin
      m_busy   = 1;
      m_rising = 1;
    end else if (se && m_busy) begin
      if (m_rising) begin
        m_env = (bus.attack_rate == 0) ? ENV_MAX : m_env + int'(bus.attack_rate);
        if (m_env >= ENV_MAX) begin m_env = ENV_MAX; m_rising = 0; end
      end else begin
        m_env = m_env - int'(bus.decay_rate);
        if (m_env <= 0) begin m_env = 0; m_busy = 0; end
      end
    end
`ifdef SYNTH_DRUM_NOISE_EN
    if (se) m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
`endif
    v = se;
    o = expected_out();
  endtask

  task automatic cycle(input bit se, input bit tr);
    bit nv;
    int no;
    @(negedge clk);
    bus.sample_en = se;
    bus.trigger   = tr;
    @(posedge clk);
    model_step(nv, no);
    #1;
    check_eq("busy", bus.busy, m_busy);
    check_eq("out_valid", bus.out_valid, pend_v);
    if (pend_v) begin
      check_eq("out", bus.out, pend_out);
      last_out = pend_out;
    end else begin
      check_eq("out_hold", bus.out, last_out);
    end
    pend_v   = nv;
    pend_out = no;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.sample_en = 1'b0;
    bus.trigger   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out", bus.out, MID);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    reset = 1'b1;
    model_init();
  endtask

  task automatic set_voice(input int f0, input int f1, input int sh0, input int sh1,
                           input int ar, input int dr, input int ng);
    bus.tone_freq[0 +: ACC_W]     = ACC_W'(f0);
    bus.tone_freq[ACC_W +: ACC_W] = ACC_W'(f1);
    bus.osc_shape[1:0]            = 2'(sh0);
    bus.osc_shape[3:2]            = 2'(sh1);
    bus.attack_rate               = ENV_W'(ar);
    bus.decay_rate                = ENV_W'(dr);
    bus.noise_gain                = ENV_W'(ng);
  endtask

  task automatic randomize_voice();
    for (int i = 0; i < NUM_OSC; i++) begin
      bus.tone_freq[i*ACC_W +: ACC_W] = ACC_W'($urandom);
      bus.osc_shape[2*i +: 2]         = 2'($urandom);
    end
    bus.attack_rate = ($urandom_range(0, 3) == 0) ? '0 : ENV_W'($urandom);
    bus.decay_rate  = ($urandom_range(0, 5) == 0) ? '0 : ENV_W'($urandom_range(1, 40));
    bus.noise_gain  = ENV_W'($urandom);
  endtask

  initial begin
    int n, lo, hi;
    bit fell;
    reset         = 1'b0;
    bus.sample_en = 1'b0;
    bus.trigger   = 1'b0;
    set_voice(0, 0, 3, 3, 0, 0, 0);
    model_init();

    // Reset values, then untriggered samples stay at midscale.
    do_reset();
    randomize_voice();
    repeat (10) cycle(1, 0);
    check_eq("idle_mid", bus.out, MID);

    // Single saw at 0x1000, instant attack, held decay.
    set_voice('h1000, 0, 2, 3, 0, 0, 0);
    cycle(0, 1);
    cycle(1, 0);
    cycle(0, 0);
    check_eq("saw_first", bus.out, MID + (((-1792 * ENV_MAX) >>> ENV_W) >>> GUARD));
    repeat (40) cycle(1, 0);

    // Attack 64 / decay 32 on alternate clocks: 12 samples until idle.
    do_reset();
    set_voice(0, 0, 0, 3, 64, 32, 0);
    cycle(0, 1);
    n = 0;
    fell = 0;
    for (int k = 0; k < 40 && !fell; k++) begin
      cycle(1, 0);
      cycle(0, 0);
      n++;
      if (bus.busy == 1'b0) fell = 1;
    end
    check_eq("env_len", n, 12);

    // Retrigger in decay at env 127 resumes attack from 127.
    cycle(0, 1);
    repeat (8) cycle(1, 0);
    cycle(0, 1);
    cycle(1, 0);
    cycle(0, 0);
    check_eq("retrig", bus.out, MID + (((-MID * 191) >>> ENV_W) >>> GUARD));

    // Two locked squares at full envelope reach both rails without wrapping.
    do_reset();
    set_voice('h0800, 'h0800, 0, 0, 0, 0, 0);
    cycle(0, 1);
    lo = FULL;
    hi = 0;
    repeat (70) begin
      cycle(1, 0);
      if (bus.out_valid) begin
        if (int'(bus.out) < lo) lo = int'(bus.out);
        if (int'(bus.out) > hi) hi = int'(bus.out);
      end
    end
    check_eq("sq_max", hi, MID + ((((2 * (FULL - MID)) * ENV_MAX) >>> ENV_W) >>> GUARD));
    check_eq("sq_min", lo, MID + (((-2 * MID * ENV_MAX) >>> ENV_W) >>> GUARD));

`ifdef SYNTH_DRUM_NOISE_EN
    // Noise only: full gain follows the LFSR, zero gain is silent.
    do_reset();
    set_voice(0, 0, 3, 3, 0, 0, 255);
    cycle(0, 1);
    repeat (40) cycle(1, 0);
    bus.noise_gain = '0;
    repeat (6) cycle(1, 0);
    check_eq("noise_off", bus.out, MID);
`endif

    // Randomized traffic with one reset in the middle.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) randomize_voice();
      if (c == 750) do_reset();
      if ((c / 200) % 2 == 1) cycle(1, $urandom_range(0, 39) == 0);
      else                    cycle($urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
